conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming sliding-window generator that sits directly upstream of the convolution MAC stage. It accepts one raster-order pixel per handshake, holds the previous KERNEL_SIZE-1 image rows in line buffers, and presents each complete KERNEL_SIZE×KERNEL_SIZE window as one flattened word. Only "valid" windows, with no padding and stride 1, are emitted. This gives (IMG_WIDTH-KERNEL_SIZE+1)×(IMG_HEIGHT-KERNEL_SIZE+1) windows per frame.

## Interface
- KERNEL_SIZE, 3, window edge length K (≥2)
- DATA_WIDTH, 8, pixel width
- IMG_WIDTH, 8, pixels per row W (≥K)
- IMG_HEIGHT, 8, rows per frame H (≥K)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- pix_valid  in  1  input pixel valid
- pix_data  in  DATA_WIDTH  input pixel, raster order
- pix_ready  out  1  block can accept pixel
- win_valid  out  1  output window valid
- win_data  out  K*K*DATA_WIDTH  window; element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 oldest (top) row, c=0 oldest (left) column
- win_last  out  1  qualifies final window of frame
- win_ready  in  1  downstream accepts window
- pix_sof  in  1  start-of-frame marker, present only with CONV_WIN_SOF_EN

## Operation
- Accept: pixel is taken when pix_valid && pix_ready. pix_ready = !win_valid || win_ready (combinational; one-entry output register).
- Line buffers: K-1 rows of W entries each. On accept, the column at col_cnt is read out (K-1 older pixels), shifted one row up, and the new pixel is written.
- Window register: K×K. On accept, the window shifts left by one column. The new right column is {line buffer rows oldest→newest, pix_data}.
- Counters: col_cnt 0..W-1, row_cnt 0..H-1, advance on accept only.
  - col wraps to 0 and increments row.
  - row wraps to 0 at end of frame, so the next frame follows seamlessly.
- Emission: an accepted pixel at (row_cnt≥K-1, col_cnt≥K-1) completes a window. win_valid is set on the next edge with the updated window.
  - win_last is set when the completing pixel is (H-1, W-1).
- Windows straddling a row wrap (col_cnt<K-1) contain stale columns and are never emitted.
- Output hold: while win_valid && !win_ready, win_data, win_last and win_valid are held, and pix_ready=0.
- A handshake with no new completing pixel clears win_valid.
- Simultaneous window handshake and completing-pixel accept: win_valid stays 1 and win_data updates to the new window (no bubble).
- Reset values: win_valid=0, win_last=0, win_data=0, counters=0, line buffers and window register cleared; pix_ready=1 after reset.
- Reset mid-frame: partial frame discarded; the next accepted pixel is (0,0).

## Timing
- Latency: 1 cycle from accepting a completing pixel to win_valid=1.
- Throughput: 1 pixel/cycle when win_ready held high.
- First window of a frame follows the accept of pixel index (K-1)*W+(K-1), which is 18 for defaults.
- Windows per frame: (W-K+1)*(H-K+1), which is 36 for defaults.
- No combinational path from pix_valid to any output. win_ready→pix_ready is the only combinational path.

## Configuration
- CONV_WIN_SOF_EN defined: pix_sof port exists.
  - A pixel accepted with pix_sof=1 is treated as (0,0) regardless of the counters, and the counters restart from it.
  - A window pending in the output register is unaffected.
- CONV_WIN_SOF_EN undefined: no pix_sof port; counters free-run and frame alignment relies solely on reset.

## Test plan
- Defaults, 8×8 frame, pixel = row*8+col, win_ready=1, continuous valid:
  - first win_valid appears the cycle after pixel 18 is accepted;
  - that window has (0,0)=0, (0,2)=2, (1,0)=8, (2,2)=18;
  - exactly 36 windows are emitted.
- Same frame: last window has (0,0)=45, (2,2)=63, win_last=1, and it is the only window with win_last=1. No window contains a column wrap (e.g. none with (0,0)=6 or 7).
- Backpressure: win_ready=0 for 5 cycles when the first window appears.
  - pix_ready=0 and win_data is stable throughout.
  - After release, the stream continues with the correct second window ((0,0)=1), and no pixel is lost or duplicated.
- Back-to-back frames: send two frames without gaps.
  - The second frame's first window matches frame 1's values; 72 windows total, with win_last on windows 36 and 72.
- Assert rst after 30 pixels, then resend the full frame: outputs are 0 during reset, pix_ready=1 after, and the window sequence is identical to the first test.
- CONV_WIN_SOF_EN: send 5 junk pixels, then the frame with pix_sof=1 on pixel 0. The window sequence is identical to the first test.

Source files
------------

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: valid windows only, stride 1, no padding.
// Define CONV_WIN_SOF_EN to add a pix_sof input that realigns the frame counters.
module conv_window_gen #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 8,
  parameter int unsigned IMG_HEIGHT  = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        pix_valid,
  input  logic [DATA_WIDTH-1:0]                       pix_data,
`ifdef CONV_WIN_SOF_EN
  input  logic                                        pix_sof,
`endif
  output logic                                        pix_ready,
  output logic                                        win_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
  output logic                                        win_last,
  input  logic                                        win_ready
);

  localparam int unsigned K  = KERNEL_SIZE;
  localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] ColMax   = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] ColFirst = CW'(K - 1);
  localparam logic [RW-1:0] RowMax   = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] RowFirst = RW'(K - 1);

  // Row 0 of the line buffer holds the oldest stored image row.
  logic [DATA_WIDTH-1:0] line_q [K-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win_q  [K][K];

  logic [CW-1:0] col_q, col_eff, col_d;
  logic [RW-1:0] row_q, row_eff, row_d;
  logic          accept, sof, complete, frame_end;
  logic          win_valid_q, win_last_q;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

`ifdef CONV_WIN_SOF_EN
  assign sof = pix_sof;
`else
  assign sof = 1'b0;
`endif

  // A start-of-frame pixel is treated as (0,0) regardless of the counters.
  always_comb begin
    col_eff   = sof ? '0 : col_q;
    row_eff   = sof ? '0 : row_q;
    complete  = (row_eff >= RowFirst) && (col_eff >= ColFirst);
    frame_end = (row_eff == RowMax) && (col_eff == ColMax);
    col_d     = col_eff + CW'(1);
    row_d     = row_eff;
    if (col_eff == ColMax) begin
      col_d = '0;
      row_d = (row_eff == RowMax) ? '0 : row_eff + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      for (int r = 0; r < int'(K) - 1; r++) begin
        for (int c = 0; c < int'(IMG_WIDTH); c++) begin
          line_q[r][c] <= '0;
        end
      end
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      col_q <= col_d;
      row_q <= row_d;
      for (int r = 0; r < int'(K) - 2; r++) begin
        line_q[r][col_eff] <= line_q[r+1][col_eff];
      end
      line_q[K-2][col_eff] <= pix_data;
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
      // New right column: stored rows oldest to newest, then the incoming pixel.
      for (int r = 0; r < int'(K) - 1; r++) begin
        win_q[r][K-1] <= line_q[r][col_eff];
      end
      win_q[K-1][K-1] <= pix_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else if (accept && complete) begin
      win_valid_q <= 1'b1;
      win_last_q  <= frame_end;
    end else if (win_ready) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign win_data[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: frame-level window model plus literal pins.
module tb_conv_window_gen;

  localparam int K   = 3;
  localparam int DW  = 8;
  localparam int W   = 8;
  localparam int H   = 8;
  localparam int WDW = K * K * DW;

  logic           clk = 1'b0;
  logic           rst;
  logic           pix_valid;
  logic [DW-1:0]  pix_data;
  logic           pix_sof;
  logic           pix_ready;
  logic           win_valid;
  logic [WDW-1:0] win_data;
  logic           win_last;
  logic           win_ready;

  always #5 clk = ~clk;

  conv_window_gen #(
    .KERNEL_SIZE(K),
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
`ifdef CONV_WIN_SOF_EN
    .pix_sof  (pix_sof),
`endif
    .pix_ready(pix_ready),
    .win_valid(win_valid),
    .win_data (win_data),
    .win_last (win_last),
    .win_ready(win_ready)
  );

  typedef struct {
    logic [WDW-1:0] data;
    logic           last;
  } exp_t;

  exp_t           exp_q[$];
  logic [WDW-1:0] hist[$];
  int             last_idx[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             win_cnt = 0;
  int             wrap_cnt = 0;
  logic           bp_arm = 1'b0;
  logic [WDW-1:0] held;

  function automatic void check(string name, logic [WDW-1:0] act, logic [WDW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] el(logic [WDW-1:0] d, int r, int c);
    return d[(r*K+c)*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] pix(int r, int c);
    return DW'(r * W + c);
  endfunction

  // Every valid window of a frame whose pixel (r,c) is r*W+c, in raster order.
  function automatic void push_frame();
    exp_t e;
    for (int r = K - 1; r < H; r++) begin
      for (int c = K - 1; c < W; c++) begin
        e.data = '0;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            e.data[(i*K+j)*DW +: DW] = pix(r - K + 1 + i, c - K + 1 + j);
          end
        end
        e.last = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void start_test();
    win_cnt  = 0;
    wrap_cnt = 0;
    hist.delete();
    last_idx.delete();
    exp_q.delete();
  endfunction

  task automatic send_pix(input logic [DW-1:0] d, input logic sof);
    logic ok;
    ok        = 1'b0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clk);
      ok = pix_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL pix_accept: got timeout expected accept");
    end
    pix_sof = 1'b0;
  endtask

  task automatic send_frame(input logic sof_first);
    for (int i = 0; i < W * H; i++) send_pix(DW'(i), sof_first && (i == 0));
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame_totals(string tag, int nwin);
    check({tag, "_win_count"}, WDW'(win_cnt), WDW'(nwin));
    check({tag, "_exp_left"}, WDW'(exp_q.size()), '0);
  endtask

  // Compare process: every window handshake against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && win_valid && win_ready) begin
      win_cnt++;
      hist.push_back(win_data);
      if (win_last) last_idx.push_back(win_cnt);
      if (el(win_data, 0, 0) == 8'd6 || el(win_data, 0, 0) == 8'd7) wrap_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_window", WDW'(win_cnt), '0);
      end else begin
        e = exp_q.pop_front();
        check("win_data", win_data, e.data);
        check("win_last", WDW'(win_last), WDW'(e.last));
      end
    end
  end

  // Downstream stall: hold win_ready low for 5 cycles at the first window once armed.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_arm && win_valid) begin
        bp_arm    = 1'b0;
        win_ready = 1'b0;
        held      = win_data;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_pix_ready", WDW'(pix_ready), '0);
          check("bp_win_valid", WDW'(win_valid), WDW'(1));
          check("bp_win_data", win_data, held);
          @(posedge clk);
          #1;
        end
        win_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sof   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_win_valid", WDW'(win_valid), '0);
    check("reset_win_last", WDW'(win_last), '0);
    check("reset_win_data", win_data, '0);
    check("reset_pix_ready", WDW'(pix_ready), WDW'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain frame: latency, first/last window literals, count, no wrap windows.
    start_test();
    push_frame();
    for (int i = 0; i < 18; i++) send_pix(DW'(i), 1'b0);
    check("t1_no_early_valid", WDW'(win_valid), '0);
    send_pix(8'd18, 1'b0);
    check("t1_first_valid", WDW'(win_valid), WDW'(1));
    check("t1_first_00", WDW'(el(win_data, 0, 0)), WDW'(0));
    check("t1_first_02", WDW'(el(win_data, 0, 2)), WDW'(2));
    check("t1_first_10", WDW'(el(win_data, 1, 0)), WDW'(8));
    check("t1_first_22", WDW'(el(win_data, 2, 2)), WDW'(18));
    for (int i = 19; i < W * H; i++) send_pix(DW'(i), 1'b0);
    idle(4);
    check_frame_totals("t1", 36);
    check("t1_last_count", WDW'(last_idx.size()), WDW'(1));
    if (last_idx.size() == 1) check("t1_last_pos", WDW'(last_idx[0]), WDW'(36));
    if (hist.size() == 36) begin
      check("t1_last_00", WDW'(el(hist[35], 0, 0)), WDW'(45));
      check("t1_last_22", WDW'(el(hist[35], 2, 2)), WDW'(63));
    end
    check("t1_wrap_windows", WDW'(wrap_cnt), '0);

    // Backpressure on the first window.
    start_test();
    push_frame();
    bp_arm = 1'b1;
    send_frame(1'b0);
    idle(4);
    check_frame_totals("t2", 36);
    if (hist.size() > 1) check("t2_second_00", WDW'(el(hist[1], 0, 0)), WDW'(1));

    // Two frames back to back.
    start_test();
    push_frame();
    push_frame();
    send_frame(1'b0);
    send_frame(1'b0);
    idle(4);
    check_frame_totals("t3", 72);
    check("t3_last_count", WDW'(last_idx.size()), WDW'(2));
    if (last_idx.size() == 2) begin
      check("t3_last_pos0", WDW'(last_idx[0]), WDW'(36));
      check("t3_last_pos1", WDW'(last_idx[1]), WDW'(72));
    end
    if (hist.size() > 36) check("t3_frame2_first", hist[36], hist[0]);

    // Reset mid-frame, then a full frame.
    start_test();
    push_frame();
    for (int i = 0; i < 30; i++) send_pix(DW'(i), 1'b0);
    pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_win_valid", WDW'(win_valid), '0);
    check("t4_rst_win_last", WDW'(win_last), '0);
    check("t4_rst_win_data", win_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_pix_ready", WDW'(pix_ready), WDW'(1));
    @(posedge clk);
    #1;
    start_test();
    push_frame();
    send_frame(1'b0);
    idle(4);
    check_frame_totals("t4", 36);
    if (hist.size() == 36) begin
      check("t4_first_22", WDW'(el(hist[0], 2, 2)), WDW'(18));
      check("t4_last_00", WDW'(el(hist[35], 0, 0)), WDW'(45));
    end

`ifdef CONV_WIN_SOF_EN
    // Junk pixels, then a frame realigned by pix_sof.
    start_test();
    push_frame();
    for (int i = 0; i < 5; i++) send_pix(DW'(8'hc0 + i), 1'b0);
    send_frame(1'b1);
    idle(4);
    check_frame_totals("t5", 36);
    if (hist.size() == 36) begin
      check("t5_first_00", WDW'(el(hist[0], 0, 0)), WDW'(0));
      check("t5_last_22", WDW'(el(hist[35], 2, 2)), WDW'(63));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
